mnist_test_sequencer: RTL and testbench
=======================================

// Module: mnist_test_sequencer
// PURPOSE
//  On-chip initiator for the mnist_top_synth accelerator handshake (start/img_sel in; valid/done/digit out).
//  On one run pulse it sweeps the embedded images in order: select, check valid, pulse start, await done,
//  compare digit to the expected label. Each verdict is streamed as ASCII bytes to a UART TX (valid/ready).
//  Sits between board button/UART TX and the accelerator; replaces the simulation-only bench on hardware.
// PARAMETERS
//  NUM_IMG     3       images swept, img_sel 0..NUM_IMG-1; legal 1..3
//  EXP0        6       expected digit for image 0
//  EXP1        2       expected digit for image 1
//  EXP2        3       expected digit for image 2
//  TIMEOUT_CYC 250000  max cycles from start pulse to done (10 ms @ 25 MHz)
//  CYC_W       20      width of cycle counter; must hold TIMEOUT_CYC
// PORTS
//  clk          in   1      system clock, 25 MHz
//  rst_n        in   1      asynchronous, active-low reset
//  run          in   1      1-cycle pulse: begin sweep; ignored while busy=1
//  acc_img_sel  out  2      image select to accelerator
//  acc_start    out  1      1-cycle start pulse to accelerator
//  acc_valid    in   1      accelerator: img_sel is a legal image
//  acc_done     in   1      accelerator done level (may remain high after a run)
//  acc_digit    in   4      accelerator predicted digit, valid when acc_done=1
//  tx_data      out  8      report byte
//  tx_valid     out  1      tx_data valid; held with tx_data stable until accepted
//  tx_ready     in   1      UART TX accepts byte when tx_valid & tx_ready at posedge clk
//  busy         out  1      sweep in progress
//  pass_cnt     out  2      images passed in current/last sweep
//  fail_cnt     out  2      images failed (mismatch, invalid or timeout)
//  all_pass     out  1      1 after sweep ends with fail_cnt==0; cleared at next run
//  last_cycles  out  CYC_W  start-to-done cycles of most recent completed inference
// BEHAVIOUR
//  Clocking: one clock; reset is asynchronous and active-low. Reset forces all outputs to 0, state IDLE.
//  Reset asserted mid-sweep: tx_valid drops at once, partial record abandoned, no summary sent.
//  FSM: IDLE -> SEL -> CHK -> STRT -> WAIT -> RPT -> (SEL | SUM) -> IDLE.
//   IDLE: run=1 -> clear pass_cnt/fail_cnt/all_pass, idx=0, busy=1, go SEL.
//   SEL : drive acc_img_sel=idx (held stable through RPT); 1 cycle for valid to settle.
//   CHK : acc_valid=0 -> verdict INVALID, go RPT; else go STRT.
//   STRT: acc_start=1 exactly this cycle; clear cycle counter; capture done_q=acc_done.
//   WAIT: counter+1 per cycle; completion = acc_done rising edge (acc_done=1 & done_q=0), so a stale
//         high done from a prior run never completes; on it latch acc_digit, last_cycles=counter.
//         Counter reaches TIMEOUT_CYC first -> verdict TIMEOUT, last_cycles unchanged.
//         Done edge and timeout same cycle -> done wins.
//   RPT : send 3 bytes: '0'+idx; then '0'+digit | 'X'(8'h58) invalid | 'T'(8'h54) timeout;
//         then 'P'(8'h50) if digit==EXPidx else 'F'(8'h46). pass_cnt/fail_cnt update on last-byte accept.
//         idx==NUM_IMG-1 -> SUM, else idx+1 -> SEL.
//   SUM : send 'S'(8'h53), '0'+pass_cnt, 8'h0A; on last accept: busy=0, all_pass=(fail_cnt==0), IDLE.
//  Byte handshake: tx_valid rises with tx_data set; both hold until tx_valid&tx_ready; next byte may
//   follow the very next cycle (back-to-back at tx_ready=1 steady). tx_ready with tx_valid=0 ignored.
//  Counters never wrap: NUM_IMG<=3 fits 2 bits. run during busy=1 has no effect (incl. during SUM).
//  Latency run->first tx_valid with ideal accelerator (done L cycles after start): L+4 cycles.
// TESTING
//  Model accelerator returns 6,2,3 with L=50, tx_ready=1 -> bytes "06P","12P","23P","S3\n", all_pass=1, last_cycles=50.
//  Model returns 7 for image 1 -> "17F", summary "S2\n", fail_cnt=1, all_pass=0.
//  Model never raises done for image 2 -> after 250000 WAIT cycles "2TF"; sweep completes, fail_cnt=1.
//  acc_done held high from previous run, new done rises at L=50 -> digit latched only at rising edge.
//  tx_ready toggles 1-of-4 cycles -> tx_data stable while tx_valid & !tx_ready; byte order unchanged; no loss.
//  run pulsed mid-WAIT, then rst_n low mid-RPT -> run ignored; reset clears outputs, busy=0, tx_valid=0.

Source files
------------

// File: rtl/mnist_test_sequencer.sv
// On-chip test initiator for the MNIST accelerator: sweeps the embedded images, checks each
// predicted digit against its label and streams an ASCII verdict record per image to a UART TX.
module mnist_test_sequencer #(
  parameter int NUM_IMG     = 3,
  parameter int EXP0        = 6,
  parameter int EXP1        = 2,
  parameter int EXP2        = 3,
  parameter int TIMEOUT_CYC = 250000,
  parameter int CYC_W       = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [1:0]       acc_img_sel,
  output logic             acc_start,
  input  logic             acc_valid,
  input  logic             acc_done,
  input  logic [3:0]       acc_digit,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [1:0]       pass_cnt,
  output logic [1:0]       fail_cnt,
  output logic             all_pass,
  output logic [CYC_W-1:0] last_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_CHK, S_STRT, S_WAIT, S_RPT, S_SUM} state_t;
  typedef enum logic [1:0] {V_OK, V_INV, V_TMO} verdict_t;

  localparam logic [1:0]       LAST_IDX = 2'(NUM_IMG - 1);
  localparam logic [CYC_W-1:0] TMO_VAL  = CYC_W'(TIMEOUT_CYC);

  function automatic logic [3:0] exp_digit(input logic [1:0] i);
    case (i)
      2'd0:    return 4'(EXP0);
      2'd1:    return 4'(EXP1);
      default: return 4'(EXP2);
    endcase
  endfunction

  state_t           state_q, state_d;
  verdict_t         verdict_q;
  logic [1:0]       idx_q;
  logic [1:0]       bcnt_q;
  logic [CYC_W-1:0] cnt_q;
  logic [CYC_W-1:0] cnt_inc;
  logic [3:0]       digit_q;
  logic             done_q;
  logic             done_edge;
  logic             tmo_hit;
  logic             tx_fire;
  logic             last_byte;
  logic             pass_now;

  assign cnt_inc     = cnt_q + CYC_W'(1);
  // Only a fresh rising edge of done counts, so a level left high by an earlier run is ignored.
  assign done_edge   = acc_done & ~done_q;
  assign tmo_hit     = (cnt_inc == TMO_VAL);
  assign tx_fire     = tx_valid & tx_ready;
  assign last_byte   = tx_fire && (bcnt_q == 2'd2);
  assign pass_now    = (verdict_q == V_OK) && (digit_q == exp_digit(idx_q));
  assign acc_img_sel = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    acc_start = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state_q)
      S_IDLE: if (run) state_d = S_SEL;
      S_SEL:  state_d = S_CHK;
      S_CHK:  state_d = acc_valid ? S_STRT : S_RPT;
      S_STRT: begin
        acc_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: if (done_edge || tmo_hit) state_d = S_RPT;
      S_RPT: begin
        tx_valid = 1'b1;
        case (bcnt_q)
          2'd0: tx_data = 8'h30 + {6'b0, idx_q};
          2'd1: begin
            case (verdict_q)
              V_INV:   tx_data = 8'h58;
              V_TMO:   tx_data = 8'h54;
              default: tx_data = 8'h30 + {4'b0, digit_q};
            endcase
          end
          default: tx_data = pass_now ? 8'h50 : 8'h46;
        endcase
        if (last_byte) state_d = (idx_q == LAST_IDX) ? S_SUM : S_SEL;
      end
      S_SUM: begin
        tx_valid = 1'b1;
        case (bcnt_q)
          2'd0:    tx_data = 8'h53;
          2'd1:    tx_data = 8'h30 + {6'b0, pass_cnt};
          default: tx_data = 8'h0A;
        endcase
        if (last_byte) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= 2'd0;
      bcnt_q      <= 2'd0;
      cnt_q       <= '0;
      digit_q     <= 4'd0;
      done_q      <= 1'b0;
      verdict_q   <= V_OK;
      busy        <= 1'b0;
      pass_cnt    <= 2'd0;
      fail_cnt    <= 2'd0;
      all_pass    <= 1'b0;
      last_cycles <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            pass_cnt <= 2'd0;
            fail_cnt <= 2'd0;
            all_pass <= 1'b0;
            idx_q    <= 2'd0;
            busy     <= 1'b1;
          end
        end
        S_CHK: if (!acc_valid) verdict_q <= V_INV;
        S_STRT: begin
          cnt_q  <= '0;
          done_q <= acc_done;
        end
        S_WAIT: begin
          cnt_q  <= cnt_inc;
          done_q <= acc_done;
          if (done_edge) begin
            digit_q     <= acc_digit;
            last_cycles <= cnt_inc;
            verdict_q   <= V_OK;
          end else if (tmo_hit) begin
            verdict_q <= V_TMO;
          end
        end
        S_RPT: begin
          if (tx_fire) bcnt_q <= bcnt_q + 2'd1;
          if (last_byte) begin
            bcnt_q <= 2'd0;
            if (pass_now) pass_cnt <= pass_cnt + 2'd1;
            else          fail_cnt <= fail_cnt + 2'd1;
            if (idx_q != LAST_IDX) idx_q <= idx_q + 2'd1;
          end
        end
        S_SUM: begin
          if (tx_fire) bcnt_q <= bcnt_q + 2'd1;
          if (last_byte) begin
            bcnt_q   <= 2'd0;
            busy     <= 1'b0;
            all_pass <= (fail_cnt == 2'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_test_sequencer.sv
// Directed bench for mnist_test_sequencer with a behavioural accelerator and a UART byte recorder.
module tb_mnist_test_sequencer;

  localparam int CYC_W = 20;
  localparam int TMO   = 200;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic [1:0]       acc_img_sel;
  logic             acc_start;
  logic             acc_valid;
  logic             acc_done = 1'b0;
  logic [3:0]       acc_digit = 4'd0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic             busy;
  logic [1:0]       pass_cnt;
  logic [1:0]       fail_cnt;
  logic             all_pass;
  logic [CYC_W-1:0] last_cycles;

  mnist_test_sequencer #(.NUM_IMG(3), .EXP0(6), .EXP1(2), .EXP2(3),
                         .TIMEOUT_CYC(TMO), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .acc_img_sel(acc_img_sel), .acc_start(acc_start), .acc_valid(acc_valid),
    .acc_done(acc_done), .acc_digit(acc_digit),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .all_pass(all_pass), .last_cycles(last_cycles)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accelerator model: done rises lat cycles after the start pulse.
  logic [3:0] dig [3];
  logic       vmask [3];
  logic       hang [3];
  int         lat = 50;
  logic       stale = 1'b0;
  logic       pre_hi = 1'b0;
  int         k = 0;
  logic       running = 1'b0;

  assign acc_valid = vmask[acc_img_sel];

  always @(posedge clk) begin
    if (pre_hi) begin
      acc_done  <= 1'b1;
      acc_digit <= 4'd9;
      running   <= 1'b0;
    end else if (acc_start) begin
      k       <= 1;
      running <= 1'b1;
      if (!stale) acc_done <= 1'b0;
    end else if (running) begin
      k <= k + 1;
      if (stale && (k + 1 == lat / 2)) acc_done <= 1'b0;
      if ((k + 1 == lat) && !hang[acc_img_sel]) begin
        acc_done  <= 1'b1;
        acc_digit <= dig[acc_img_sel];
        running   <= 1'b0;
      end
    end
  end

  // UART side: ready pattern, byte recorder, hold-stability watcher.
  logic [7:0] q [$];
  int         rdy_mode = 0;
  int         cyc = 0;
  int         viol = 0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) q.push_back(tx_data);
    if (rst_n && pv && !pr && (!tx_valid || tx_data != pd)) viol++;
    pv = tx_valid && rst_n;
    pr = tx_ready;
    pd = tx_data;
    #1;
    cyc++;
    tx_ready = (rdy_mode == 1) ? ((cyc % 4) == 0) : 1'b1;
  end

  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic do_sweep(input string tag, output int lat_o);
    int n;
    q.delete();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    n = 1;
    while (!tx_valid && n < 3000) begin @(negedge clk); n++; end
    lat_o = n;
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic check_bytes(input string tag, input string s);
    check({tag, "_len"}, q.size(), s.len());
    for (int i = 0; i < s.len(); i++)
      check($sformatf("%s_b%0d", tag, i), (i < q.size()) ? q[i] : 8'h00, s[i]);
  endtask

  task automatic set_model();
    dig[0] = 4'd6; dig[1] = 4'd2; dig[2] = 4'd3;
    for (int i = 0; i < 3; i++) begin vmask[i] = 1'b1; hang[i] = 1'b0; end
    stale = 1'b0; lat = 50; rdy_mode = 0;
  endtask

  initial begin
    int l;
    int n;
    set_model();
    #23;
    check("rst_busy", busy, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_start", acc_start, 0);
    check("rst_sel", acc_img_sel, 0);
    check("rst_last", last_cycles, 0);
    check("rst_allp", all_pass, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_sweep("ok", l);
    check("ok_latency", l, 54);
    check_bytes("ok", "06P12P23PS3\n");
    check("ok_pass", pass_cnt, 3);
    check("ok_fail", fail_cnt, 0);
    check("ok_allp", all_pass, 1);
    check("ok_last", last_cycles, 50);

    dig[1] = 4'd7;
    do_sweep("mis", l);
    check_bytes("mis", "06P17F23PS2\n");
    check("mis_pass", pass_cnt, 2);
    check("mis_fail", fail_cnt, 1);
    check("mis_allp", all_pass, 0);

    set_model();
    hang[2] = 1'b1;
    do_sweep("tmo", l);
    check_bytes("tmo", "06P12P2TFS2\n");
    check("tmo_fail", fail_cnt, 1);
    check("tmo_last", last_cycles, 50);

    set_model();
    stale = 1'b1;
    pre_hi = 1'b1;
    repeat (2) @(negedge clk);
    pre_hi = 1'b0;
    do_sweep("stale", l);
    check_bytes("stale", "06P12P23PS3\n");
    check("stale_last", last_cycles, 50);
    check("stale_allp", all_pass, 1);

    set_model();
    rdy_mode = 1;
    do_sweep("rdy", l);
    check_bytes("rdy", "06P12P23PS3\n");
    check("rdy_hold", viol, 0);
    rdy_mode = 0;

    vmask[1] = 1'b0;
    do_sweep("inv", l);
    check_bytes("inv", "06P1XF23PS2\n");
    check("inv_fail", fail_cnt, 1);
    set_model();

    q.delete();
    pulse_run();
    repeat (10) @(negedge clk);
    pulse_run();
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    repeat (100) @(negedge clk);
    check_bytes("rerun", "06P12P23PS3\n");
    check("rerun_busy", busy, 0);

    q.delete();
    pulse_run();
    n = 0;
    while (!tx_valid && n < 3000) begin @(negedge clk); n++; end
    check("rpt_reached", tx_valid, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_txv", tx_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_pass", pass_cnt, 0);
    check("arst_last", last_cycles, 0);
    check("arst_sel", acc_img_sel, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_txv", tx_valid, 0);
    check("post_rst_len", q.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
